// File: rtl/iwm_write_serializer.sv
// IWM write path: buffers CPU-written bytes and shifts them MSB-first onto an NRZI write line.
// Optional IWM_WR_SYNC_PAD_EN: on underrun, pad with 8'hFF sync bytes instead of halting.
module iwm_write_serializer #(
  parameter int BIT_CELL_CEN = 16,
  parameter int CNT_W        = 5
) (
  input  logic       clk,
  input  logic       _reset,
  input  logic       cen,
  input  logic       wrEnable,
  input  logic       dataStrobe,
  input  logic [7:0] dataIn,
  output logic       _iwmBusy,
  output logic       _writeUnderrun,
  output logic       wrData,
  output logic       wrBitStrobe,
  output logic       byteDone,
  output logic [7:0] byteOut
);

  typedef enum logic [1:0] {IDLE, SHIFT, UNDERRUN} state_t;

  localparam logic [CNT_W-1:0] CELL_RELOAD = CNT_W'(BIT_CELL_CEN - 1);

  state_t           state, state_nxt;
  logic [7:0]       buf_dat;
  logic [7:0]       shreg;     // bit 7 is the next bit to emit
  logic [7:0]       cur_byte;
  logic [CNT_W-1:0] cell_cnt;
  logic [3:0]       cell_num;  // cells already started in the current byte
  logic             buf_full;
  logic             load, take_buf, cell_start, boundary, underrun_set;
  logic [7:0]       byte_src;

  assign buf_full = ~_iwmBusy;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    take_buf     = 1'b0;
    cell_start   = 1'b0;
    boundary     = 1'b0;
    underrun_set = 1'b0;
    byte_src     = buf_dat;
    if (!wrEnable) begin
      state_nxt = IDLE;
    end else if (cen) begin
      case (state)
        IDLE: begin
          if (buf_full) begin
            load       = 1'b1;
            take_buf   = 1'b1;
            cell_start = 1'b1;
            state_nxt  = SHIFT;
          end
        end
        SHIFT: begin
          if (cell_cnt == '0) begin
            cell_start = 1'b1;
            if (cell_num == 4'd8) begin
              boundary = 1'b1;
              if (buf_full) begin
                load     = 1'b1;
                take_buf = 1'b1;
              end else begin
                underrun_set = 1'b1;
`ifdef IWM_WR_SYNC_PAD_EN
                load     = 1'b1;
                byte_src = 8'hFF;
`else
                cell_start = 1'b0;
                state_nxt  = UNDERRUN;
`endif
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      _iwmBusy       <= 1'b1;
      _writeUnderrun <= 1'b1;
      wrData         <= 1'b0;
      wrBitStrobe    <= 1'b0;
      byteDone       <= 1'b0;
      byteOut        <= 8'h00;
      buf_dat        <= 8'h00;
      shreg          <= 8'h00;
      cur_byte       <= 8'h00;
      cell_cnt       <= '0;
      cell_num       <= 4'd0;
    end else begin
      wrBitStrobe <= 1'b0;
      byteDone    <= 1'b0;
      if (!wrEnable) begin
        // Abort: partial byte is discarded, line level and last byteOut are kept
        _iwmBusy       <= 1'b1;
        _writeUnderrun <= 1'b1;
      end else begin
        // A strobe coinciding with a transfer wins: shifter takes the old byte, new one stays buffered
        if (dataStrobe) begin
          buf_dat  <= dataIn;
          _iwmBusy <= 1'b0;
        end else if (take_buf) begin
          _iwmBusy <= 1'b1;
        end
        if (underrun_set) _writeUnderrun <= 1'b0;
        if (boundary) begin
          byteDone <= 1'b1;
          byteOut  <= cur_byte;
        end
        if (cell_start) begin
          wrBitStrobe <= 1'b1;
          cell_cnt    <= CELL_RELOAD;
          if (load) begin
            shreg    <= byte_src << 1;
            cur_byte <= byte_src;
            cell_num <= 4'd1;
            wrData   <= wrData ^ byte_src[7];
          end else begin
            shreg    <= shreg << 1;
            cell_num <= cell_num + 4'd1;
            wrData   <= wrData ^ shreg[7];
          end
        end else if (cen && state == SHIFT) begin
          cell_cnt <= cell_cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_iwm_write_serializer.sv
// Directed bench for iwm_write_serializer; cen runs two ticks out of every three clocks.
module tb_iwm_write_serializer;
  logic       clk = 1'b0, rst_n = 1'b0, cen_hold = 1'b0, wr_en = 1'b0, strobe = 1'b0;
  logic [7:0] din = 8'h00;
  logic       cen;
  logic [1:0] phase = 2'd0;
  logic       busy_n, ur_n, wr_data, bit_stb, byte_done;
  logic [7:0] byte_out;
  int         tick = 0, total = 0, passed = 0;
  int         st_q[$];
  logic       wd_q[$];
  int         bd_q[$];
  logic [7:0] bo_q[$];
  logic [7:0] exp_bytes [4];
  logic       lvl0, lvl_hold;

  iwm_write_serializer dut (
    .clk(clk), ._reset(rst_n), .cen(cen), .wrEnable(wr_en), .dataStrobe(strobe), .dataIn(din),
    ._iwmBusy(busy_n), ._writeUnderrun(ur_n), .wrData(wr_data), .wrBitStrobe(bit_stb),
    .byteDone(byte_done), .byteOut(byte_out)
  );

  always #5 clk = ~clk;
  always @(negedge clk) phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
  assign cen = !cen_hold && (phase != 2'd0);
  always @(posedge clk) if (cen) tick <= tick + 1;

  always @(negedge clk) begin
    if (bit_stb)   begin st_q.push_back(tick); wd_q.push_back(wr_data);  end
    if (byte_done) begin bd_q.push_back(tick); bo_q.push_back(byte_out); end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_q();
    st_q.delete(); wd_q.delete(); bd_q.delete(); bo_q.delete();
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk); din = b; strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
  endtask

  task automatic wait_st(input int n, input string tag);
    int k = 0;
    while (st_q.size() < n && k < 3000) begin @(negedge clk); k++; end
    chk(tag, 32'(st_q.size() >= n), 1);
  endtask

  task automatic wait_bd(input int n, input string tag);
    int k = 0;
    while (bd_q.size() < n && k < 3000) begin @(negedge clk); k++; end
    chk(tag, 32'(bd_q.size() >= n), 1);
  endtask

  task automatic wait_busy(input logic v, input string tag);
    int k = 0;
    while (busy_n !== v && k < 3000) begin @(negedge clk); k++; end
    chk(tag, 32'(busy_n), 32'(v));
  endtask

  task automatic reidle();
    @(negedge clk); wr_en = 1'b0;
    repeat (2) @(negedge clk);
    wr_en = 1'b1;
  endtask

  // Cell count, cell spacing, NRZI levels from the reference bytes, byteDone timing and values
  task automatic verify(input int nbytes, input logic start_lvl, input string tag);
    int gap_bad = 0, wd_bad = 0, bd_bad = 0;
    logic lvl;
    logic [7:0] b;
    lvl = start_lvl;
    chk({tag, "_cells"}, 32'(st_q.size()), 32'(8 * nbytes));
    chk({tag, "_bytes"}, 32'(bd_q.size()), 32'(nbytes));
    for (int i = 1; i < st_q.size(); i++)
      if (st_q[i] - st_q[i-1] != 16) gap_bad++;
    for (int i = 0; i < st_q.size() && i < 8 * nbytes; i++) begin
      b = exp_bytes[i / 8];
      lvl = lvl ^ b[7 - (i % 8)];
      if (wd_q[i] !== lvl) wd_bad++;
    end
    for (int j = 0; j < bd_q.size() && j < nbytes && 8 * j < st_q.size(); j++)
      if (bd_q[j] - st_q[8 * j] != 128 || bo_q[j] !== exp_bytes[j]) bd_bad++;
    chk({tag, "_gaps"}, 32'(gap_bad), 0);
    chk({tag, "_nrzi"}, 32'(wd_bad), 0);
    chk({tag, "_bytedone"}, 32'(bd_bad), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({busy_n, ur_n, wr_data, bit_stb, byte_done, byte_out}),
        32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    rst_n = 1'b1;
    @(negedge clk); wr_en = 1'b1;
    @(negedge clk);

`ifdef IWM_WR_SYNC_PAD_EN
    clear_q();
    write_byte(8'hDE);
    chk("pad_busy_lo", 32'(busy_n), 0);
    wait_bd(1, "pad_de_done");
    repeat (2) @(negedge clk);
    chk("pad_ur_first_pad", 32'(ur_n), 0);
    wait_st(12, "pad_mid");
    write_byte(8'hAA);
    chk("pad_aa_buffered", 32'(busy_n), 0);
    wait_bd(3, "pad_three_done");
    chk("pad_byte0", 32'(bo_q[0]), 32'h0DE);
    chk("pad_byte1", 32'(bo_q[1]), 32'h0FF);
    chk("pad_byte2", 32'(bo_q[2]), 32'h0AA);
    chk("pad_ur_still_lo", 32'(ur_n), 0);
    chk("pad_aa_taken", 32'(busy_n), 1);
    chk("pad_gap", 32'(bd_q[2] - bd_q[0]), 256);
    reidle();
`else
    // Single byte D5: toggles in cells 0,1,3,5,7 -> final level 1
    clear_q(); lvl0 = wr_data; exp_bytes[0] = 8'hD5;
    write_byte(8'hD5);
    chk("t1_busy_lo", 32'(busy_n), 0);
    wait_busy(1'b1, "t1_busy_hi");
    wait_bd(1, "t1_done");
    repeat (3) @(negedge clk);
    verify(1, lvl0, "t1");
    chk("t1_underrun", 32'(ur_n), 0);
    chk("t1_level", 32'(wr_data), 1);
    reidle();
    chk("t1_exit", 32'({busy_n, ur_n}), 32'h3);

    // Back-to-back D5, AA, 96
    clear_q(); lvl0 = wr_data;
    exp_bytes[0] = 8'hD5; exp_bytes[1] = 8'hAA; exp_bytes[2] = 8'h96;
    write_byte(8'hD5);
    wait_busy(1'b1, "t2_b0_load");
    write_byte(8'hAA);
    chk("t2_b1_buffered", 32'(busy_n), 0);
    wait_busy(1'b1, "t2_b1_load");
    chk("t2_ur_mid", 32'(ur_n), 1);
    write_byte(8'h96);
    wait_busy(1'b1, "t2_b2_load");
    chk("t2_ur_before_end", 32'(ur_n), 1);
    wait_bd(3, "t2_done");
    repeat (2) @(negedge clk);
    verify(3, lvl0, "t2");
    chk("t2_underrun", 32'(ur_n), 0);
    reidle();

    // FF then underrun: line static, strobe does not restart
    clear_q(); lvl0 = wr_data; exp_bytes[0] = 8'hFF;
    write_byte(8'hFF);
    wait_bd(1, "t3_done");
    repeat (2) @(negedge clk);
    verify(1, lvl0, "t3");
    chk("t3_underrun", 32'(ur_n), 0);
    lvl_hold = wr_data;
    repeat (110) @(negedge clk);
    chk("t3_static", 32'(wr_data), 32'(lvl_hold));
    write_byte(8'h55);
    chk("t3_strobe_buffers", 32'(busy_n), 0);
    repeat (60) @(negedge clk);
    chk("t3_no_restart", 32'(st_q.size()), 8);
    chk("t3_ur_sticky", 32'(ur_n), 0);
    reidle();
    chk("t3_exit", 32'({busy_n, ur_n}), 32'h3);

    // Abort 96 after 3 cells, then a clean restart with 3C
    clear_q();
    write_byte(8'h96);
    wait_st(3, "t4_three_cells");
    wr_en = 1'b0;
    lvl_hold = wr_data;
    @(negedge clk);
    chk("t4_abort_flags", 32'({busy_n, ur_n}), 32'h3);
    repeat (60) @(negedge clk);
    chk("t4_no_more_cells", 32'(st_q.size()), 3);
    chk("t4_no_bytedone", 32'(bd_q.size()), 0);
    chk("t4_byteout_held", 32'(byte_out), 32'h0FF);
    chk("t4_level_held", 32'(wr_data), 32'(lvl_hold));
    wr_en = 1'b1;
    clear_q(); lvl0 = wr_data; exp_bytes[0] = 8'h3C;
    write_byte(8'h3C);
    wait_bd(1, "t4_restart_done");
    repeat (2) @(negedge clk);
    verify(1, lvl0, "t4");
    reidle();

    // Two strobes before any transfer: last write wins
    clear_q(); lvl0 = wr_data; exp_bytes[0] = 8'h22;
    @(negedge clk); cen_hold = 1'b1;
    @(negedge clk); din = 8'h11; strobe = 1'b1;
    @(negedge clk); din = 8'h22;
    @(negedge clk); strobe = 1'b0;
    chk("t5_busy_lo", 32'(busy_n), 0);
    cen_hold = 1'b0;
    wait_bd(1, "t5_done");
    repeat (2) @(negedge clk);
    verify(1, lvl0, "t5");
    reidle();
`endif

    // Asynchronous reset in the middle of a byte
    clear_q();
    write_byte(8'h81);
    wait_st(2, "rst_mid_cells");
    #3 rst_n = 1'b0;
    #1 chk("async_reset", 32'({busy_n, ur_n, wr_data, bit_stb, byte_done, byte_out}),
           32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
